// File: rtl/flash_read_arbiter_pkg.sv
// Shared types and constants for the two-requester flash read arbiter.
package flash_arb_pkg;

  localparam int NUM_REQ         = 2;
  localparam int TIMEOUT_DEFAULT = 1023;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DATA = 2'd2
  } arb_state_t;

endpackage

// File: rtl/flash_read_arbiter_rr.sv
// Combinational two-way round-robin picker: a lone request wins outright,
// a tie goes to whichever requester was not granted last.
module flash_arb_rr
  import flash_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last_grant,
  output logic               gnt_valid,
  output logic               gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = 1'b0;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last_grant;
      default: gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/flash_read_arbiter.sv
// Shares the flash core's single Avalon-MM read port between two requesters,
// one single-beat read at a time, with a watchdog on the returning data.
module flash_read_arbiter
  import flash_arb_pkg::*;
#(
  parameter int ADDR_W  = 23,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_read,
  input  logic [ADDR_W-1:0] r0_address,
  output logic              r0_waitrequest,
  output logic [DATA_W-1:0] r0_readdata,
  output logic              r0_readdatavalid,
  input  logic              r1_read,
  input  logic [ADDR_W-1:0] r1_address,
  output logic              r1_waitrequest,
  output logic [DATA_W-1:0] r1_readdata,
  output logic              r1_readdatavalid,
  output logic              flash_mem_read,
  output logic [ADDR_W-1:0] flash_mem_address,
  input  logic              flash_mem_waitrequest,
  input  logic [DATA_W-1:0] flash_mem_readdata,
  input  logic              flash_mem_readdatavalid,
  output logic              owner,
  output logic              busy,
  output logic              timeout_err
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              read_q, busy_q;
  logic              gnt_valid, gnt_idx;
  logic              accept, data_hit, tmo_hit;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;

  flash_arb_rr u_rr (
    .req        ({r1_read, r0_read}),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  assign accept   = (state_q == ISSUE) && !flash_mem_waitrequest;
  assign data_hit = (state_q == WAIT_DATA) && flash_mem_readdatavalid;
  // Valid data in the final watchdog cycle wins over the abort.
  assign tmo_hit  = (state_q == WAIT_DATA) && !flash_mem_readdatavalid && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (gnt_valid) state_d = ISSUE;
      ISSUE:     if (accept) state_d = WAIT_DATA;
      WAIT_DATA: if (data_hit || tmo_hit) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d       = addr_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    if (state_q == IDLE && gnt_valid) begin
      addr_d       = gnt_idx ? r1_address : r0_address;
      owner_d      = gnt_idx;
      last_grant_d = gnt_idx;
    end
    if (accept) begin
      cnt_d = '0;
    end else if (state_q == WAIT_DATA && !flash_mem_readdatavalid) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // The flash-facing strobe and status flags are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      read_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      read_q       <= (state_d == ISSUE);
      busy_q       <= (state_d != IDLE);
    end
  end

  always_comb begin
    resp_valid       = data_hit || tmo_hit;
    resp_data        = data_hit ? flash_mem_readdata : '0;
    r0_waitrequest   = 1'b1;
    r1_waitrequest   = 1'b1;
    r0_readdatavalid = 1'b0;
    r1_readdatavalid = 1'b0;
    r0_readdata      = '0;
    r1_readdata      = '0;
    timeout_err      = tmo_hit;
    if (accept) begin
      if (owner_q) r1_waitrequest = 1'b0;
      else         r0_waitrequest = 1'b0;
    end
    if (resp_valid) begin
      if (owner_q) begin
        r1_readdatavalid = 1'b1;
        r1_readdata      = resp_data;
      end else begin
        r0_readdatavalid = 1'b1;
        r0_readdata      = resp_data;
      end
    end
  end

  assign flash_mem_read    = read_q;
  assign flash_mem_address = addr_q;
  assign owner             = owner_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Self-checking bench for flash_read_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level round-robin model.
module tb_flash_read_arbiter;

  localparam int ADDR_W  = 23;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              r0_read = 1'b0, r1_read = 1'b0;
  logic [ADDR_W-1:0] r0_address = '0, r1_address = '0;
  logic              r0_waitrequest, r1_waitrequest;
  logic [DATA_W-1:0] r0_readdata, r1_readdata;
  logic              r0_readdatavalid, r1_readdatavalid;
  logic              flash_mem_read;
  logic [ADDR_W-1:0] flash_mem_address;
  logic              flash_mem_waitrequest = 1'b1;
  logic [DATA_W-1:0] flash_mem_readdata = '0;
  logic              flash_mem_readdatavalid = 1'b0;
  logic              owner, busy, timeout_err;

  int nChecks = 0;
  int nFail   = 0;

  int          wsCfg = 0, latCfg = 1, randWs = 0, wCnt = 0, pend = 0;
  int          flushReq = 0, flushSeen = 0, strayReq = 0, straySeen = 0;
  bit          randMode = 1'b0, neverValid = 1'b0, fixedEn = 1'b0;
  logic [31:0] fixedData = '0, pData = '0;

  flash_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .r0_read                 (r0_read),
    .r0_address              (r0_address),
    .r0_waitrequest          (r0_waitrequest),
    .r0_readdata             (r0_readdata),
    .r0_readdatavalid        (r0_readdatavalid),
    .r1_read                 (r1_read),
    .r1_address              (r1_address),
    .r1_waitrequest          (r1_waitrequest),
    .r1_readdata             (r1_readdata),
    .r1_readdatavalid        (r1_readdatavalid),
    .flash_mem_read          (flash_mem_read),
    .flash_mem_address       (flash_mem_address),
    .flash_mem_waitrequest   (flash_mem_waitrequest),
    .flash_mem_readdata      (flash_mem_readdata),
    .flash_mem_readdatavalid (flash_mem_readdatavalid),
    .owner                   (owner),
    .busy                    (busy),
    .timeout_err             (timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] flash_word(input logic [ADDR_W-1:0] a);
    return {a[15:0] ^ 16'hC3A5, a[22:7]};
  endfunction

  // Flash core model: holds waitrequest for a number of cycles, then returns data
  // a fixed (or random) number of cycles after the accept cycle.
  always @(negedge clk) begin
    flash_mem_readdatavalid = 1'b0;
    flash_mem_readdata      = '0;
    if (flushSeen != flushReq) begin
      flushSeen = flushReq;
      pend      = 0;
      wCnt      = 0;
    end
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        flash_mem_readdatavalid = 1'b1;
        flash_mem_readdata      = pData;
      end
    end
    if (straySeen != strayReq) begin
      straySeen               = strayReq;
      flash_mem_readdatavalid = 1'b1;
      flash_mem_readdata      = 32'h1234_5678;
    end
    flash_mem_waitrequest = 1'b1;
    if (flash_mem_read) begin
      if (wCnt < (randMode ? randWs : wsCfg)) begin
        wCnt++;
      end else begin
        flash_mem_waitrequest = 1'b0;
        wCnt   = 0;
        pData  = fixedEn ? fixedData : flash_word(flash_mem_address);
        pend   = neverValid ? 0 : (randMode ? int'($urandom_range(1, TIMEOUT)) : latCfg);
        randWs = int'($urandom_range(0, 2));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    r0_read    = 1'b0;
    r1_read    = 1'b0;
    r0_address = '0;
    r1_address = '0;
    randMode   = 1'b0;
    neverValid = 1'b0;
    fixedEn    = 1'b0;
    wsCfg      = 0;
    latCfg     = 1;
    flushReq++;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    nChecks++;
    if ({flash_mem_read, owner, busy, timeout_err, r0_waitrequest, r1_waitrequest,
         r0_readdatavalid, r1_readdatavalid} !== 8'b0000_1100) begin
      nFail++;
      $display("[TB] FAIL reset_ctrl: got %b expected 00001100", {flash_mem_read, owner, busy,
               timeout_err, r0_waitrequest, r1_waitrequest, r0_readdatavalid, r1_readdatavalid});
    end
    nChecks++;
    if ({flash_mem_address, r0_readdata, r1_readdata} !== '0) begin
      nFail++;
      $display("[TB] FAIL reset_data: got addr %h d0 %h d1 %h expected all 0",
               flash_mem_address, r0_readdata, r1_readdata);
    end
    do_reset();
  endtask

  task automatic test_single();
    int               firstRd = -1, accCyc = -1, datCyc = -1, n0 = 0, n1 = 0;
    logic [31:0]      got0 = '0;
    logic [ADDR_W-1:0] seenAddr = '0;
    logic             busyAfter = 1'b1;
    do_reset();
    wsCfg      = 2;
    latCfg     = 3;
    fixedEn    = 1'b1;
    fixedData  = 32'hDEAD_BEEF;
    r0_address = 23'h000010;
    r0_read    = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (datCyc > 0 && c == datCyc + 1) busyAfter = busy;
      if (flash_mem_read && firstRd < 0) begin
        firstRd  = c;
        seenAddr = flash_mem_address;
      end
      if (!r0_waitrequest && accCyc < 0) begin
        accCyc  = c;
        r0_read = 1'b0;
      end
      if (r0_readdatavalid) begin
        n0++;
        datCyc = c;
        got0   = r0_readdata;
      end
      if (r1_readdatavalid) n1++;
    end
    nChecks++;
    if (firstRd != 1) begin nFail++; $display("[TB] FAIL single_issue_cycle: got %0d expected 1", firstRd); end
    nChecks++;
    if (seenAddr !== 23'h000010) begin nFail++; $display("[TB] FAIL single_addr: got %h expected 000010", seenAddr); end
    nChecks++;
    if (accCyc != 3) begin nFail++; $display("[TB] FAIL single_accept_cycle: got %0d expected 3", accCyc); end
    nChecks++;
    if (datCyc != 6) begin nFail++; $display("[TB] FAIL single_data_cycle: got %0d expected 6", datCyc); end
    nChecks++;
    if (n0 != 1 || got0 !== 32'hDEAD_BEEF) begin
      nFail++; $display("[TB] FAIL single_r0_data: got %0d pulses data %h expected 1 pulse deadbeef", n0, got0);
    end
    nChecks++;
    if (n1 != 0) begin nFail++; $display("[TB] FAIL single_r1_quiet: got %0d pulses expected 0", n1); end
    nChecks++;
    if (busyAfter !== 1'b0) begin nFail++; $display("[TB] FAIL single_back_idle: busy %b expected 0", busyAfter); end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] order[$];
    logic [ADDR_W-1:0] expOrder[4] = '{23'h100, 23'h200, 23'h100, 23'h200};
    int                n0 = 0, n1 = 0;
    do_reset();
    r0_address = 23'h100;
    r1_address = 23'h200;
    r0_read    = 1'b1;
    r1_read    = 1'b1;
    for (int c = 1; c <= 60 && (order.size() < 4 || n0 + n1 < 4); c++) begin
      step();
      if (flash_mem_read && !flash_mem_waitrequest) begin
        order.push_back(flash_mem_address);
        if (order.size() == 4) begin
          r0_read = 1'b0;
          r1_read = 1'b0;
        end
      end
      if (r0_readdatavalid) n0++;
      if (r1_readdatavalid) n1++;
    end
    nChecks++;
    if (order.size() != 4) begin
      nFail++; $display("[TB] FAIL b2b_count: got %0d reads expected 4", order.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        nChecks++;
        if (order[i] !== expOrder[i]) begin
          nFail++; $display("[TB] FAIL b2b_order[%0d]: got %h expected %h", i, order[i], expOrder[i]);
        end
      end
    end
    nChecks++;
    if (n0 != 2 || n1 != 2) begin
      nFail++; $display("[TB] FAIL b2b_pulses: got r0 %0d r1 %0d expected 2 and 2", n0, n1);
    end
  endtask

  task automatic test_timeout();
    int          accCyc = -1, tmoCyc = -1, nTmo = 0;
    logic        v0 = 1'b0, v1 = 1'b1, busyAfter = 1'b1;
    logic [31:0] d0 = '1;
    do_reset();
    neverValid = 1'b1;
    r0_address = 23'h000020;
    r0_read    = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (tmoCyc > 0 && c == tmoCyc + 1) busyAfter = busy;
      if (!r0_waitrequest && accCyc < 0) begin
        accCyc  = c;
        r0_read = 1'b0;
      end
      if (timeout_err) begin
        nTmo++;
        if (tmoCyc < 0) begin
          tmoCyc = c;
          v0     = r0_readdatavalid;
          d0     = r0_readdata;
          v1     = r1_readdatavalid;
        end
      end
    end
    nChecks++;
    if (tmoCyc - accCyc != TIMEOUT || accCyc < 0) begin
      nFail++; $display("[TB] FAIL tmo_delay: got %0d cycles after accept expected %0d", tmoCyc - accCyc, TIMEOUT);
    end
    nChecks++;
    if (nTmo != 1) begin nFail++; $display("[TB] FAIL tmo_pulses: got %0d expected 1", nTmo); end
    nChecks++;
    if ({v0, v1} !== 2'b10 || d0 !== '0) begin
      nFail++; $display("[TB] FAIL tmo_response: got v0 %b v1 %b d0 %h expected 1 0 0", v0, v1, d0);
    end
    nChecks++;
    if (busyAfter !== 1'b0) begin nFail++; $display("[TB] FAIL tmo_back_idle: busy %b expected 0", busyAfter); end
  endtask

  task automatic test_latched_request();
    int                nAcc = 0, n0 = 0, n1 = 0;
    logic [ADDR_W-1:0] accAddr = '0;
    logic [31:0]       got1 = '0;
    do_reset();
    wsCfg      = 1;
    latCfg     = 2;
    r1_address = 23'h000055;
    r1_read    = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 1) begin
        r1_read    = 1'b0;
        r1_address = 23'h0003FF;
      end
      if (flash_mem_read && !flash_mem_waitrequest) accAddr = flash_mem_address;
      if (!r1_waitrequest) nAcc++;
      if (r0_readdatavalid) n0++;
      if (r1_readdatavalid) begin
        n1++;
        got1 = r1_readdata;
      end
    end
    nChecks++;
    if (accAddr !== 23'h000055) begin nFail++; $display("[TB] FAIL latch_addr: got %h expected 000055", accAddr); end
    nChecks++;
    if (nAcc != 1) begin nFail++; $display("[TB] FAIL latch_accept: got %0d expected 1", nAcc); end
    nChecks++;
    if (n1 != 1 || got1 !== flash_word(23'h000055) || n0 != 0) begin
      nFail++; $display("[TB] FAIL latch_data: got r1 %0d pulses data %h r0 %0d expected 1 %h 0",
                        n1, got1, n0, flash_word(23'h000055));
    end
  endtask

  task automatic test_reset_mid_read();
    int nV = 0;
    do_reset();
    latCfg     = 6;
    r0_address = 23'h000040;
    r0_read    = 1'b1;
    step();
    r0_read = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    nChecks++;
    if ({flash_mem_read, owner, busy, timeout_err, r0_waitrequest, r1_waitrequest,
         r0_readdatavalid, r1_readdatavalid} !== 8'b0000_1100 || flash_mem_address !== '0) begin
      nFail++;
      $display("[TB] FAIL midrst_values: got %b addr %h expected 00001100 addr 0", {flash_mem_read, owner,
               busy, timeout_err, r0_waitrequest, r1_waitrequest, r0_readdatavalid, r1_readdatavalid},
               flash_mem_address);
    end
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      if (r0_readdatavalid || r1_readdatavalid || timeout_err || busy) nV++;
    end
    nChecks++;
    if (nV != 0) begin nFail++; $display("[TB] FAIL midrst_no_pulse: got %0d active cycles expected 0", nV); end
    r0_address = 23'h000100;
    r1_address = 23'h000200;
    r0_read    = 1'b1;
    r1_read    = 1'b1;
    step();
    nChecks++;
    if ({flash_mem_read, owner} !== 2'b10 || flash_mem_address !== 23'h000100) begin
      nFail++; $display("[TB] FAIL midrst_next_grant: got read %b owner %b addr %h expected 1 0 000100",
                        flash_mem_read, owner, flash_mem_address);
    end
    r0_read = 1'b0;
    r1_read = 1'b0;
  endtask

  task automatic test_stray_valid();
    do_reset();
    step();
    strayReq++;
    for (int c = 0; c < 2; c++) begin
      step();
      nChecks++;
      if ({flash_mem_read, owner, busy, timeout_err, r0_waitrequest, r1_waitrequest,
           r0_readdatavalid, r1_readdatavalid} !== 8'b0000_1100 || {r0_readdata, r1_readdata} !== '0) begin
        nFail++;
        $display("[TB] FAIL stray_valid[%0d]: got %b d0 %h d1 %h expected 00001100 and zero data", c,
                 {flash_mem_read, owner, busy, timeout_err, r0_waitrequest, r1_waitrequest,
                  r0_readdatavalid, r1_readdatavalid}, r0_readdata, r1_readdata);
      end
    end
  endtask

  task automatic test_random();
    int                phase = 0, startPhase = 0, c = 0, grants = 0, resps = 0;
    bit                done = 1'b0, dataNow;
    bit                reqV[2] = '{1'b0, 1'b0};
    logic [ADDR_W-1:0] reqA[2] = '{'0, '0};
    logic              expOwner = 1'b0, lastG = 1'b1, expWr0, expWr1;
    logic [ADDR_W-1:0] expAddr = '0;
    logic [DATA_W-1:0] expD;
    do_reset();
    randMode = 1'b1;
    while (!done) begin
      step();
      c++;
      expWr0 = !(phase == 1 && expOwner == 1'b0 && !flash_mem_waitrequest);
      expWr1 = !(phase == 1 && expOwner == 1'b1 && !flash_mem_waitrequest);
      nChecks++;
      if ({r0_waitrequest, r1_waitrequest} !== {expWr0, expWr1}) begin
        nFail++; $display("[TB] FAIL rand_waitreq @%0d: got %b%b expected %b%b", c,
                          r0_waitrequest, r1_waitrequest, expWr0, expWr1);
      end
      nChecks++;
      if ({flash_mem_read, busy} !== {phase == 1, phase != 0}) begin
        nFail++; $display("[TB] FAIL rand_ctrl @%0d: got read %b busy %b expected phase %0d", c,
                          flash_mem_read, busy, phase);
      end
      if (phase != 0) begin
        nChecks++;
        if ({owner, flash_mem_address} !== {expOwner, expAddr}) begin
          nFail++; $display("[TB] FAIL rand_issue @%0d: got owner %b addr %h expected %b %h", c,
                            owner, flash_mem_address, expOwner, expAddr);
        end
      end
      dataNow = (phase == 2) && flash_mem_readdatavalid;
      expD    = dataNow ? flash_word(expAddr) : '0;
      nChecks++;
      if ({r0_readdatavalid, r1_readdatavalid, timeout_err} !== {dataNow && !expOwner, dataNow && expOwner, 1'b0} ||
          r0_readdata !== (expOwner ? DATA_W'(0) : expD) || r1_readdata !== (expOwner ? expD : DATA_W'(0))) begin
        nFail++; $display("[TB] FAIL rand_resp @%0d: got v %b%b tmo %b d0 %h d1 %h expected owner %b valid %b data %h",
                          c, r0_readdatavalid, r1_readdatavalid, timeout_err, r0_readdata, r1_readdata,
                          expOwner, dataNow, expD);
      end
      startPhase = phase;
      if (phase == 1 && !flash_mem_waitrequest) begin
        phase          = 2;
        reqV[expOwner] = 1'b0;
      end else if (dataNow) begin
        phase = 0;
        resps++;
      end
      for (int i = 0; i < 2; i++) begin
        if (!reqV[i] && c < 300 && $urandom_range(0, 2) != 0) begin
          reqV[i] = 1'b1;
          reqA[i] = ADDR_W'($urandom);
        end
      end
      r0_read    = reqV[0];
      r0_address = reqA[0];
      r1_read    = reqV[1];
      r1_address = reqA[1];
      if (startPhase == 0 && (reqV[0] || reqV[1])) begin
        expOwner = (reqV[0] && reqV[1]) ? !lastG : reqV[1];
        lastG    = expOwner;
        expAddr  = reqA[expOwner];
        phase    = 1;
        grants++;
      end
      if (c >= 300 && phase == 0 && !reqV[0] && !reqV[1]) done = 1'b1;
      if (c >= 700) begin
        nChecks++;
        nFail++;
        $display("[TB] FAIL rand_drain: still in phase %0d after %0d cycles, expected idle", phase, c);
        done = 1'b1;
      end
    end
    nChecks++;
    if (resps != grants || grants < 10) begin
      nFail++; $display("[TB] FAIL rand_totals: got %0d responses for %0d grants expected equal and >= 10", resps, grants);
    end
    r0_read = 1'b0;
    r1_read = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_latched_request();
    test_reset_mid_read();
    test_stray_valid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation still running at %0t expected finish", $time);
    $fatal(1, "[TB] simulation time limit");
  end

endmodule
